calc2_port_issuer: RTL
======================

Name: calc2_port_issuer

Overview:
- Request/response adapter that sits directly upstream of one calc2_top port; one instance per port (4 total).
- Accepts whole operations (cmd, op1, op2, id) from a host over a valid/ready handshake.
- Allocates a free calc2 tag and serialises each operation into the two-cycle calc2 request protocol.
- Captures calc2 responses by tag and returns them to the host, with the original id, through a 4-entry response FIFO.

Parameters:
- ID_W, 4, width of the host transaction id.
- STAT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- c_clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = asserted)
- cmd_valid  in  1  host operation valid
- cmd_ready  out  1  issuer accepts the operation this cycle
- cmd_op  in  4  calc2 command code
- cmd_op1  in  32  operand 1
- cmd_op2  in  32  operand 2
- cmd_id  in  ID_W  host id, returned with the response
- req_cmd  out  4  to calc2 reqN_cmd_in
- req_data  out  32  to calc2 reqN_data_in
- req_tag  out  2  to calc2 reqN_tag_in
- out_resp  in  2  from calc2 out_respN; nonzero = response present
- out_data  in  32  from calc2 out_dataN
- out_tag  in  2  from calc2 out_tagN
- rsp_valid  out  1  response available to the host
- rsp_ready  in  1  host accepts the response
- rsp_resp  out  2  calc2 response code
- rsp_data  out  32  result
- rsp_id  out  ID_W  id of the originating operation
- tag_err  out  1  sticky: a response arrived for a non-outstanding tag

Behaviour:
- Reset values:
  - req_cmd, req_data, req_tag = 0.
  - cmd_ready = 0.
  - rsp_valid = 0; rsp_resp, rsp_data, rsp_id = 0.
  - tag_err = 0.
  - Outstanding mask = 0; FIFO empty; FSM in IDLE.
- Tag state: a 4-bit outstanding mask plus a 4-entry id table indexed by tag.
- Tag lifetime: a tag is set on issue and cleared only when its response is popped from the FIFO (rsp_valid && rsp_ready). Operations in flight plus responses buffered therefore never exceed 4, and the FIFO cannot overflow.
- FSM IDLE:
  - cmd_ready = 1 (combinational) iff any tag is free. Free means clear in the registered mask; a tag freed this cycle is usable next cycle.
  - On cmd_valid && cmd_ready:
    - allocate the lowest free tag and record cmd_id in the id table;
    - latch op2;
    - register req_cmd = cmd_op, req_data = cmd_op1, req_tag = tag;
    - move to OP2.
  - Otherwise req_cmd = 0, req_data = 0, req_tag = 0.
- FSM OP2: cmd_ready = 0; register req_cmd = 0, req_data = latched op2, req_tag = 0; return to IDLE.
- Timing: request first-beat latency is 1 cycle after the handshake, second beat 2 cycles after. Maximum throughput is one operation per 2 cycles.
- cmd_op is not filtered. Invalid codes are issued as-is, and calc2 answers them with resp 2.
- Response capture: when out_resp != 0 at a clock edge:
  - if out_tag is outstanding and not already captured, push {out_resp, out_data, id_table[out_tag]} into the FIFO and mark the tag captured;
  - otherwise drop the response and set tag_err.
- Response output: the FIFO head drives rsp_*. rsp_valid = FIFO not empty. rsp_* hold stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop in the same cycle: both occur and the count is unchanged. A pop of tag T and a push on a different tag in the same cycle is legal.
- Same-cycle allocate of tag X and free of tag Y is legal. X is taken from the pre-free mask.
- Responses return in calc2 order, not issue order. FIFO order equals response arrival order.
- Reset mid-operation clears all state, including any pending OP2 beat. Responses arriving after reset release hit empty tags and set tag_err.
- tag_err clears only on reset.

Optional Feature:
- Macro CALC2_ISSUER_STATS_EN.
- When defined:
  - ports issued_cnt (out, STAT_W) and done_cnt (out, STAT_W) exist;
  - issued_cnt increments on each accepted host operation;
  - done_cnt increments on each FIFO pop;
  - both reset to 0 and wrap modulo 2^STAT_W.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package calc2_issuer_pkg holds:
  - constants CALC2_TAG_W=2, CALC2_NUM_TAGS=4, CALC2_CMD_W=4, CALC2_DATA_W=32;
  - command codes CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - response codes RESP_NONE=0, RESP_OK=1, RESP_OVF=2;
  - typedef enum {IDLE, OP2} issuer_state_t;
  - the response-entry struct.
- One sub-module: calc2_rsp_fifo, a 4-deep synchronous FIFO for the response entry, with the same clock and reset.

Test Plan:
- ADD 0x5 + 0x3, id 7 -> req beats {1, 0x5, tag 0} then {0, 0x3, 0}; calc2 returns resp 1, data 0x8, tag 0 -> rsp {1, 0x8, id 7}.
- Five back-to-back operations with responses withheld -> tags 0, 1, 2, 3 issued; cmd_ready low for the fifth until one response is popped, after which the fifth issues on the freed tag.
- Responses returned in order tags 2, 0, 3, 1 with rsp_ready held low for 10 cycles -> FIFO holds 4 entries, no loss, and pops return ids in arrival order.
- Inject out_resp 1 on tag 3 while nothing is outstanding -> response dropped, tag_err = 1 and stays set until reset.
- Drive reset low during the OP2 beat -> req_* = 0 immediately, mask cleared, cmd_ready = 1 after release, FIFO empty.
- SUB 0x1 - 0x2 -> calc2 resp 2 is passed through unchanged as rsp_resp = 2; with CALC2_ISSUER_STATS_EN, issued_cnt = done_cnt = 1.

Source files
------------

// File: rtl/calc2_issuer_pkg.sv
// Shared constants, codes and types for the calc2 port issuer.
package calc2_issuer_pkg;

    localparam int CALC2_TAG_W    = 2;
    localparam int CALC2_NUM_TAGS = 4;
    localparam int CALC2_CMD_W    = 4;
    localparam int CALC2_DATA_W   = 32;

    localparam logic [CALC2_CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CALC2_CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CALC2_CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CALC2_CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CALC2_CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;

    typedef enum logic {IDLE, OP2} issuer_state_t;

    typedef struct packed {
        logic [1:0]              resp;
        logic [CALC2_DATA_W-1:0] data;
        logic [CALC2_TAG_W-1:0]  tag;
    } rsp_entry_t;

    // Highest index is visited first so the lowest clear bit wins.
    function automatic logic [CALC2_TAG_W-1:0] lowest_free(input logic [CALC2_NUM_TAGS-1:0] mask);
        logic [CALC2_TAG_W-1:0] result;
        result = '0;
        for (int i = CALC2_NUM_TAGS - 1; i >= 0; i--) begin
            if (!mask[i]) result = CALC2_TAG_W'(i);
        end
        return result;
    endfunction

endpackage

// File: rtl/calc2_port_issuer_if.sv
// Host and calc2-port signal bundle for the issuer; slave = issuer side.
interface calc2_port_issuer_if #(parameter int ID_W = 4);

    logic                                     cmd_valid;
    logic                                     cmd_ready;
    logic [calc2_issuer_pkg::CALC2_CMD_W-1:0] cmd_op;
    logic [calc2_issuer_pkg::CALC2_DATA_W-1:0] cmd_op1;
    logic [calc2_issuer_pkg::CALC2_DATA_W-1:0] cmd_op2;
    logic [ID_W-1:0]                          cmd_id;

    logic [calc2_issuer_pkg::CALC2_CMD_W-1:0] req_cmd;
    logic [calc2_issuer_pkg::CALC2_DATA_W-1:0] req_data;
    logic [calc2_issuer_pkg::CALC2_TAG_W-1:0] req_tag;

    logic [1:0]                               out_resp;
    logic [calc2_issuer_pkg::CALC2_DATA_W-1:0] out_data;
    logic [calc2_issuer_pkg::CALC2_TAG_W-1:0] out_tag;

    logic                                     rsp_valid;
    logic                                     rsp_ready;
    logic [1:0]                               rsp_resp;
    logic [calc2_issuer_pkg::CALC2_DATA_W-1:0] rsp_data;
    logic [ID_W-1:0]                          rsp_id;

    logic                                     tag_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_op1, cmd_op2, cmd_id,
        output cmd_ready,
        output req_cmd, req_data, req_tag,
        input  out_resp, out_data, out_tag,
        output rsp_valid, rsp_resp, rsp_data, rsp_id,
        input  rsp_ready,
        output tag_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_op1, cmd_op2, cmd_id,
        input  cmd_ready,
        input  req_cmd, req_data, req_tag,
        output out_resp, out_data, out_tag,
        input  rsp_valid, rsp_resp, rsp_data, rsp_id,
        output rsp_ready,
        input  tag_err
    );

endinterface

// File: rtl/calc2_rsp_fifo.sv
// Four-deep response FIFO; the head entry is presented combinationally.
module calc2_rsp_fifo
    import calc2_issuer_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic            c_clk,
    input  logic            reset,
    input  logic            push,
    input  rsp_entry_t      push_entry,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            valid,
    output rsp_entry_t      head_entry,
    output logic [ID_W-1:0] head_id
);

    rsp_entry_t      mem    [CALC2_NUM_TAGS];
    logic [ID_W-1:0] id_mem [CALC2_NUM_TAGS];
    logic [1:0]      wr_ptr;
    logic [1:0]      rd_ptr;
    logic [2:0]      count;
    logic            do_push;
    logic            do_pop;

    assign do_pop     = pop && (count != 3'd0);
    assign do_push    = push && ((count != 3'd4) || do_pop);
    assign valid      = (count != 3'd0);
    assign head_entry = mem[rd_ptr];
    assign head_id    = id_mem[rd_ptr];

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CALC2_NUM_TAGS; i++) begin
                mem[i]    <= '0;
                id_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr]    <= push_entry;
                id_mem[wr_ptr] <= push_id;
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/calc2_port_issuer.sv
// Host-to-calc2 port adapter: tag allocation, two-beat request issue, response FIFO.
// Optional CALC2_ISSUER_STATS_EN adds issued_cnt/done_cnt counters.
module calc2_port_issuer
    import calc2_issuer_pkg::*;
#(
    parameter int ID_W = 4
`ifdef CALC2_ISSUER_STATS_EN
   ,parameter int STAT_W = 16
`endif
) (
    input  logic               c_clk,
    input  logic               reset,
    calc2_port_issuer_if.slave bus
`ifdef CALC2_ISSUER_STATS_EN
   ,output logic [STAT_W-1:0]  issued_cnt,
    output logic [STAT_W-1:0]  done_cnt
`endif
);

    issuer_state_t           state;
    issuer_state_t           state_next;
    logic [CALC2_NUM_TAGS-1:0] mask;
    logic [CALC2_NUM_TAGS-1:0] captured;
    logic [ID_W-1:0]         id_table [CALC2_NUM_TAGS];
    logic [CALC2_DATA_W-1:0] op2_q;
    logic [CALC2_CMD_W-1:0]  req_cmd_d;
    logic [CALC2_DATA_W-1:0] req_data_d;
    logic [CALC2_TAG_W-1:0]  req_tag_d;
    logic [CALC2_TAG_W-1:0]  alloc_tag;
    logic                    ready;
    logic                    fire;
    logic                    resp_present;
    logic                    hit;
    logic                    pop;
    logic [CALC2_NUM_TAGS-1:0] alloc_onehot;
    logic [CALC2_NUM_TAGS-1:0] push_onehot;
    logic [CALC2_NUM_TAGS-1:0] free_onehot;
    rsp_entry_t              push_entry;
    rsp_entry_t              head;
    logic [ID_W-1:0]         head_id;
    logic                    fifo_valid;

    assign alloc_tag     = lowest_free(mask);
    assign fire          = bus.cmd_valid && ready;
    assign bus.cmd_ready = ready;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        req_cmd_d  = '0;
        req_data_d = '0;
        req_tag_d  = '0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so the port looks busy.
                ready = reset && (mask != '1);
                if (bus.cmd_valid && ready) begin
                    req_cmd_d  = bus.cmd_op;
                    req_data_d = bus.cmd_op1;
                    req_tag_d  = alloc_tag;
                    state_next = OP2;
                end
            end
            OP2: begin
                req_data_d = op2_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_present = (bus.out_resp != RESP_NONE);
    assign hit          = resp_present && mask[bus.out_tag] && !captured[bus.out_tag];
    assign pop          = fifo_valid && bus.rsp_ready;
    assign alloc_onehot = fire ? (4'b0001 << alloc_tag) : '0;
    assign push_onehot  = hit ? (4'b0001 << bus.out_tag) : '0;
    assign free_onehot  = pop ? (4'b0001 << head.tag) : '0;
    assign push_entry   = '{resp: bus.out_resp, data: bus.out_data, tag: bus.out_tag};

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bus.req_cmd  <= '0;
            bus.req_data <= '0;
            bus.req_tag  <= '0;
            mask         <= '0;
            captured     <= '0;
            op2_q        <= '0;
            bus.tag_err  <= 1'b0;
            for (int i = 0; i < CALC2_NUM_TAGS; i++) id_table[i] <= '0;
        end else begin
            state        <= state_next;
            bus.req_cmd  <= req_cmd_d;
            bus.req_data <= req_data_d;
            bus.req_tag  <= req_tag_d;
            mask         <= (mask | alloc_onehot) & ~free_onehot;
            captured     <= (captured | push_onehot) & ~free_onehot;
            if (fire) begin
                id_table[alloc_tag] <= bus.cmd_id;
                op2_q               <= bus.cmd_op2;
            end
            if (resp_present && !hit) bus.tag_err <= 1'b1;
        end
    end

    calc2_rsp_fifo #(.ID_W(ID_W)) u_fifo (
        .c_clk      (c_clk),
        .reset      (reset),
        .push       (hit),
        .push_entry (push_entry),
        .push_id    (id_table[bus.out_tag]),
        .pop        (bus.rsp_ready),
        .valid      (fifo_valid),
        .head_entry (head),
        .head_id    (head_id)
    );

    assign bus.rsp_valid = fifo_valid;
    assign bus.rsp_resp  = head.resp;
    assign bus.rsp_data  = head.data;
    assign bus.rsp_id    = head_id;

`ifdef CALC2_ISSUER_STATS_EN
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
            done_cnt   <= '0;
        end else begin
            if (fire) issued_cnt <= issued_cnt + 1'b1;
            if (pop)  done_cnt   <= done_cnt + 1'b1;
        end
    end
`endif

endmodule
